// File: rtl/freq_hash_probe_if.sv
// Key stream and hash-table RAM port bundle for freq_hash_probe.
// Key handshake: a key transfers on a rising edge where key_valid and key_ready are both high; key_data must hold while key_valid waits.
interface freq_hash_probe_if #(
  parameter int KEY_W  = 32,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 7
);
  logic              key_valid;
  logic [KEY_W-1:0]  key_data;
  logic              key_ready;
  logic [ADDR_W-1:0] tbl_addr;
  logic [KEY_W-1:0]  tbl_key_rd;
  logic [CNT_W-1:0]  tbl_cnt_rd;
  logic              tbl_we;
  logic [KEY_W-1:0]  tbl_key_wr;
  logic [CNT_W-1:0]  tbl_cnt_wr;

  modport master (
    input  key_valid, key_data, tbl_key_rd, tbl_cnt_rd,
    output key_ready, tbl_addr, tbl_we, tbl_key_wr, tbl_cnt_wr
  );

  modport slave (
    output key_valid, key_data, tbl_key_rd, tbl_cnt_rd,
    input  key_ready, tbl_addr, tbl_we, tbl_key_wr, tbl_cnt_wr
  );
endinterface

// File: rtl/freq_hash_probe.sv
// Key-occurrence counter over an external 1-cycle-latency RAM using open
// addressing with linear probing; saturating counts, pause/resume, full-table drop.
module freq_hash_probe #(
  parameter int KEY_W    = 32,
  parameter int CNT_W    = 32,
  parameter int ADDR_W   = 7,
  parameter int NUM_KEYS = 100,
  parameter int IDX_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic               resume_i,
  output logic               busy_o,
  output logic               paused_o,
  output logic               done_o,
  output logic [IDX_W-1:0]   key_index_o,
  output logic [31:0]        collisions_o,
  output logic [15:0]        dropped_o,
  output logic               table_full_o,
  output logic [2:0]         state_o,
  freq_hash_probe_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_READ    = 3'd2,
    S_COMPARE = 3'd3,
    S_WRITE   = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6,
    S_PAUSED  = 3'd7
  } state_t;

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(NUM_KEYS);

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] probe_q, probe_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       coll_q, coll_d;
  logic [15:0]       drop_q, drop_d;
  logic              full_q, full_d;
  logic              plat_q, plat_d;
  logic              done_q, done_d;
  logic [KEY_W-1:0]  wkey_q, wkey_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;

  logic              slot_empty;
  logic              slot_hit;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDX_W:0]    idx_inc;
  logic              busy;

  assign slot_empty = (bus.tbl_cnt_rd == '0);
  assign slot_hit   = !slot_empty && (bus.tbl_key_rd == key_q);
  assign cnt_inc    = (bus.tbl_cnt_rd == '1) ? bus.tbl_cnt_rd : bus.tbl_cnt_rd + CNT_W'(1);
  assign idx_inc    = {1'b0, idx_q} + (IDX_W+1)'(1);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_PAUSED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      addr_q  <= '0;
      probe_q <= '0;
      idx_q   <= '0;
      coll_q  <= '0;
      drop_q  <= '0;
      full_q  <= 1'b0;
      plat_q  <= 1'b0;
      done_q  <= 1'b0;
      wkey_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      probe_q <= probe_d;
      idx_q   <= idx_d;
      coll_q  <= coll_d;
      drop_q  <= drop_d;
      full_q  <= full_d;
      plat_q  <= plat_d;
      done_q  <= done_d;
      wkey_q  <= wkey_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    addr_d  = addr_q;
    probe_d = probe_q;
    idx_d   = idx_q;
    coll_d  = coll_q;
    drop_d  = drop_q;
    full_d  = full_q;
    plat_d  = plat_q;
    done_d  = 1'b0;
    wkey_d  = wkey_q;
    wcnt_d  = wcnt_q;

    // A pause request seen mid-key is remembered until the key boundary.
    if (busy && pause_i) plat_d = 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          idx_d   = '0;
          coll_d  = '0;
          drop_d  = '0;
          full_d  = 1'b0;
          plat_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.key_valid) begin
          key_d   = bus.key_data;
          addr_d  = bus.key_data[ADDR_W-1:0];
          probe_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_COMPARE;
      S_COMPARE: begin
        if (slot_hit) begin
          wkey_d  = key_q;
          wcnt_d  = cnt_inc;
          state_d = S_WRITE;
        end else if (slot_empty) begin
          wkey_d  = key_q;
          wcnt_d  = CNT_W'(1);
          state_d = S_WRITE;
        end else if (probe_q == '1) begin
          // Every slot visited without a match or a hole: drop the key.
          full_d  = 1'b1;
          if (drop_q != '1) drop_d = drop_q + 16'd1;
          state_d = S_NEXT;
        end else begin
          probe_d = probe_q + ADDR_W'(1);
          if (coll_q != '1) coll_d = coll_q + 32'd1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        idx_d = idx_inc[IDX_W-1:0];
        if (idx_inc == LAST_IDX) begin
          done_d  = 1'b1;
          plat_d  = 1'b0;
          state_d = S_DONE;
        end else if (pause_i || plat_q) begin
          plat_d  = 1'b0;
          state_d = S_PAUSED;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_PAUSED: begin
        if (resume_i && !pause_i) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.key_ready  = (state_q == S_FETCH);
  assign bus.tbl_we     = (state_q == S_WRITE);
  assign bus.tbl_addr   = addr_q;
  assign bus.tbl_key_wr = wkey_q;
  assign bus.tbl_cnt_wr = wcnt_q;

  assign busy_o       = busy;
  assign paused_o     = (state_q == S_PAUSED);
  assign done_o       = done_q;
  assign key_index_o  = idx_q;
  assign collisions_o = coll_q;
  assign dropped_o    = drop_q;
  assign table_full_o = full_q;
  assign state_o      = state_q;

endmodule
